// File: rtl/qr_cordic_scheduler_if.sv
// Command channel between the QR Givens-rotation scheduler and the shared CORDIC engine.
// master = scheduler side, slave = engine side.
interface qr_cordic_scheduler_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_row_a;
    logic [1:0] cmd_row_b;
    logic [2:0] cmd_col;
    logic       cmd_done;

    modport master (
        output cmd_valid, cmd_op, cmd_row_a, cmd_row_b, cmd_col,
        input  cmd_ready, cmd_done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_row_a, cmd_row_b, cmd_col,
        output cmd_ready, cmd_done
    );
endinterface

// File: rtl/qr_cordic_scheduler.sv
// Issues the 66-command complex Givens QR schedule for a 4x5 [H|Y] matrix to one CORDIC engine.
// Optional stall counter output o_stall_cycles is built when QR_SCHED_PERF_EN is defined.
module qr_cordic_scheduler #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned OCNT_W          = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
`ifdef QR_SCHED_PERF_EN
    output logic [15:0] o_stall_cycles,
`endif
    qr_cordic_scheduler_if.master cmd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_VEC,
        S_WAIT_VEC,
        S_ISSUE_ROT,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [OCNT_W-1:0] OCNT_MAX = OCNT_W'(MAX_OUTSTANDING);
    localparam logic [OCNT_W-1:0] OCNT_ONE = OCNT_W'(1);

    state_t            state;
    logic              stage_givens;
    logic [1:0]        j_q;
    logic [1:0]        i_q;
    logic [2:0]        k_q;
    logic [OCNT_W-1:0] ocnt;

    logic xfer;
    logic done_ok;
    logic rot_room;
    logic drained;

    // A completion arriving in the same cycle frees a slot, so a full window can still issue.
    always_comb begin
        done_ok       = cmd.cmd_done && (ocnt != '0);
        rot_room      = (ocnt < OCNT_MAX) || cmd.cmd_done;
        cmd.cmd_valid = (state == S_ISSUE_VEC) || ((state == S_ISSUE_ROT) && rot_room);
        xfer          = cmd.cmd_valid && cmd.cmd_ready;
        drained       = (ocnt == '0) || ((ocnt == OCNT_ONE) && cmd.cmd_done);
    end

    always_comb begin
        cmd.cmd_op    = {stage_givens, (state == S_ISSUE_ROT)};
        cmd.cmd_row_b = i_q;
        cmd.cmd_row_a = stage_givens ? (i_q - 2'd1) : i_q;
        cmd.cmd_col   = (state == S_ISSUE_ROT) ? k_q : {1'b0, j_q};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ocnt  <= '0;
            o_err <= 1'b0;
        end else begin
            if (cmd.cmd_done && (ocnt == '0)) begin
                o_err <= 1'b1;
            end
            if (xfer && !done_ok) begin
                ocnt <= ocnt + OCNT_ONE;
            end else if (!xfer && done_ok) begin
                ocnt <= ocnt - OCNT_ONE;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= S_IDLE;
            stage_givens <= 1'b0;
            j_q          <= '0;
            i_q          <= '0;
            k_q          <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        stage_givens <= 1'b0;
                        j_q          <= '0;
                        i_q          <= '0;
                        k_q          <= '0;
                        o_busy       <= 1'b1;
                        state        <= S_ISSUE_VEC;
                    end
                end
                S_ISSUE_VEC: begin
                    if (xfer) begin
                        state <= S_WAIT_VEC;
                    end
                end
                S_WAIT_VEC: begin
                    if (done_ok) begin
                        k_q   <= {1'b0, j_q} + 3'd1;
                        state <= S_ISSUE_ROT;
                    end
                end
                S_ISSUE_ROT: begin
                    if (xfer) begin
                        if (k_q == 3'd4) begin
                            state <= S_DRAIN;
                        end else begin
                            k_q <= k_q + 3'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drained) begin
                        if (!stage_givens) begin
                            if (i_q == 2'd3) begin
                                // Last column has no rows left below the diagonal to annihilate.
                                if (j_q == 2'd3) begin
                                    o_done <= 1'b1;
                                    state  <= S_DONE;
                                end else begin
                                    stage_givens <= 1'b1;
                                    state        <= S_ISSUE_VEC;
                                end
                            end else begin
                                i_q   <= i_q + 2'd1;
                                state <= S_ISSUE_VEC;
                            end
                        end else begin
                            if ((i_q - 2'd1) == j_q) begin
                                j_q          <= j_q + 2'd1;
                                i_q          <= j_q + 2'd1;
                                stage_givens <= 1'b0;
                            end else begin
                                i_q <= i_q - 2'd1;
                            end
                            state <= S_ISSUE_VEC;
                        end
                    end
                end
                S_DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef QR_SCHED_PERF_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_stall_cycles <= '0;
        end else if ((state == S_IDLE) && i_start) begin
            o_stall_cycles <= '0;
        end else if (o_busy && !xfer && (o_stall_cycles != '1)) begin
            o_stall_cycles <= o_stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: doc/qr_cordic_scheduler.md
Name: qr_cordic_scheduler

Overview:
Sequences one shared CORDIC processing element through the complete Givens-rotation schedule for complex QR decomposition of the 4x4 channel matrix H, augmented with Y as column 4 (4 rows x 5 columns, 0-indexed). It starts when the input collector flags a full H/Y set, then emits an ordered stream of vectoring and rotation commands over a valid/ready handshake. It tracks engine completions and enforces the data dependencies between commands. Sits between the input collector and the CORDIC array / matrix register file.

Parameters:
MAX_OUTSTANDING, 4, max rotation commands accepted by the engine but not yet completed (1..7)
OCNT_W, 3, width of outstanding counter; must hold MAX_OUTSTANDING

Ports:
i_clk  in  1  clock; one clock domain
i_rst  in  1  reset, asynchronous, active-high
i_start  in  1  1-cycle pulse when the H/Y set is complete (input collector data-valid)
o_busy  out  1  high from the cycle after start is accepted until DONE is exited
o_cmd_valid  out  1  command presented
i_cmd_ready  in  1  engine accepts the command this cycle
o_cmd_op  out  2  0=VEC_PHASE, 1=ROT_PHASE, 2=VEC_GIVENS, 3=ROT_GIVENS
o_cmd_row_a  out  2  first row operand
o_cmd_row_b  out  2  second row operand (equals row_a for phase ops)
o_cmd_col  out  3  column operand 0..4 (4 = Y)
i_cmd_done  in  1  one pulse per completed command; completions return in issue order
o_done  out  1  1-cycle pulse when the whole schedule has completed
o_err  out  1  sticky flag: done pulse received with no command outstanding

Behaviour:
- Reset: all outputs 0; state IDLE; counters and pointers 0. Asserting i_rst at any point aborts the sequence immediately; no o_done is generated.
- Handshake: a command transfers when o_cmd_valid && i_cmd_ready. While valid && !ready, op, rows and col hold stable and valid stays high.
- Outstanding counter: +1 on transfer, -1 on i_cmd_done; no change when both occur in the same cycle. Saturates at 0. A done pulse with count 0 sets o_err and is otherwise ignored.
- Schedule, per column j = 0..3:
  - Phase stage, row i = j..3: VEC_PHASE(i,i,col j), then ROT_PHASE(i,i,col k) for k = j+1..4.
  - Givens stage, row i = 3 down to j+1: VEC_GIVENS(i-1,i,col j), then ROT_GIVENS(i-1,i,col k) for k = j+1..4.
- Command count: 66 total (35/20/9/2 for j = 0/1/2/3), of which 16 are vectoring commands.
- FSM:
  - IDLE: if i_start, load j=0, phase stage, i=0, then go to ISSUE_VEC. i_start in any other state is ignored.
  - ISSUE_VEC: valid high with the vectoring op. On transfer, go to WAIT_VEC.
  - WAIT_VEC: valid low. On i_cmd_done, set k=j+1 and go to ISSUE_ROT. The angle must exist before any dependent rotation is issued.
  - ISSUE_ROT: valid high only while outstanding < MAX_OUTSTANDING, or while outstanding == MAX_OUTSTANDING and i_cmd_done is high in the same cycle. On transfer, increment k. The transfer with k==4 goes to DRAIN.
  - DRAIN: valid low. When outstanding==0, or outstanding==1 with a done in the current cycle, advance the pointers:
    - phase stage: i++; past row 3, switch to the Givens stage with i=3, or to DONE if j==3.
    - Givens stage: i--; on reaching i==j, set j++, return to the phase stage with i=j, and go to ISSUE_VEC.
  - DONE: o_done=1 for one cycle, then IDLE.
- o_busy is low only in IDLE. Back-to-back ready gives one rotation transfer per cycle.

Optional Feature:
QR_SCHED_PERF_EN
- Defined: adds output o_stall_cycles[15:0], cleared on start acceptance and saturating at 16'hFFFF. It increments on every busy cycle with no command transfer; the value holds after o_done.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Start pulse, engine always ready, done 1 cycle after each transfer -> exactly 66 transfers, then one o_done pulse, o_busy low after, o_err 0. Commands 1-5 are VEC_PHASE(0,0,0), ROT_PHASE(0,0,1..4). Command 21 is VEC_GIVENS(2,3,0). Command 66 is ROT_PHASE(3,3,4).
- MAX_OUTSTANDING=4 and dones withheld after the first vector completes -> exactly 4 ROT_PHASE transfers (cols 1..4), then DRAIN with valid low. Releasing one done does not issue the next VEC_PHASE until all 4 have completed.
- i_cmd_ready low for 5 cycles while VEC_PHASE(0,0,0) is presented -> valid high and fields unchanged for all 5 cycles; one transfer when ready rises.
- Second i_start pulse during command 10 -> ignored; still exactly 66 commands and one o_done.
- i_rst asserted at command 30, then released and restarted -> all outputs 0 during reset; fresh sequence starts at VEC_PHASE(0,0,0); o_done only after 66 new commands.
- i_cmd_done pulse while in IDLE -> o_err=1 and stays 1 until reset; with QR_SCHED_PERF_EN defined, the 5-cycle-ready-low run yields an o_stall_cycles value that includes those 5 cycles.
